lms_train_ctrl: RTL

- Sequences the 3-tap adaptive FIR/LMS datapath through coefficient clear, training with adaptation on, and tracking with coefficients frozen.
- Monitors the mean absolute error over fixed windows to decide convergence, retraining and timeout.
- Gates sample acceptance with a valid/ready handshake.
- Sits between the sample source and the adaptive filter; drives its adapt-enable and coefficient-clear controls.

---
 rtl/lms_train_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lms_train_ctrl.sv
// lms_train_ctrl: sequences a 3-tap adaptive FIR/LMS datapath through
// coefficient clear, training (adaptation on) and tracking (coefficients
// frozen). It averages |error| over fixed windows to decide convergence,
// retraining and training timeout, and gates sample acceptance with a
// valid/ready handshake.
module lms_train_ctrl #(
  parameter int NB_DATA    = 32,
  parameter int LOG2_WIN   = 4,
  parameter int CONV_WINS  = 2,
  parameter int MAX_WINS   = 8,
  parameter int CLR_CYCLES = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_sample_en,
  input  logic                       i_err_valid,
  input  logic signed [NB_DATA-1:0]  i_error,
  input  logic signed [NB_DATA-1:0]  i_thresh_lo,
  input  logic signed [NB_DATA-1:0]  i_thresh_hi,
  output logic                       o_coef_clr,
  output logic                       o_adapt_en,
  output logic [1:0]                 o_state,
  output logic                       o_converged,
  output logic                       o_timeout,
  output logic [7:0]                 o_retrain_cnt,
  output logic [NB_DATA-1:0]         o_mean_err
);

  // Accumulator holds a full window of |error| without overflow.
  localparam int ACC_W  = NB_DATA + LOG2_WIN;
  localparam int CONV_W = $clog2(CONV_WINS + 1);
  localparam int WIN_W  = $clog2(MAX_WINS + 1);
  localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [CONV_W-1:0] CONV_TGT = CONV_W'(CONV_WINS);
  localparam logic [WIN_W-1:0]  WIN_TGT  = WIN_W'(MAX_WINS);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    TRAIN = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [LOG2_WIN-1:0]  smp_cnt;
  logic [CONV_W-1:0]    conv_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [CLR_W-1:0]     clr_cnt;

  logic                 vld_p0;
  logic                 done_p0;
  logic [NB_DATA-1:0]   abs_p0;
  logic [ACC_W-1:0]     sum_p0;
  logic [NB_DATA-1:0]   mean_p0;
  logic                 lo_hit;
  logic                 hi_hit;
  logic [CONV_W-1:0]    conv_nxt;
  logic [WIN_W-1:0]     win_nxt;

  // Magnitude with the most-negative code clamped to the largest positive
  // value, so the result always fits in NB_DATA-1 magnitude bits.
  function automatic logic [NB_DATA-1:0] abs_sat(input logic signed [NB_DATA-1:0] x);
    logic [NB_DATA-1:0] most_neg;
    most_neg = {1'b1, {(NB_DATA-1){1'b0}}};
    if (x == most_neg)
      abs_sat = {1'b0, {(NB_DATA-1){1'b1}}};
    else if (x[NB_DATA-1])
      abs_sat = $unsigned(-x);
    else
      abs_sat = $unsigned(x);
  endfunction

  assign o_state     = state;
  assign o_sample_en = i_valid & o_ready;

  // ---- stage p0: error magnitude, window sum and window decision inputs ----
  // Combinational accumulate-and-compare for the error arriving this cycle.
  always_comb begin
    vld_p0   = i_err_valid && ((state == TRAIN) || (state == TRACK));
    abs_p0   = abs_sat(i_error);
    sum_p0   = acc + ACC_W'(abs_p0);
    done_p0  = vld_p0 && (smp_cnt == {LOG2_WIN{1'b1}});
    mean_p0  = sum_p0[ACC_W-1:LOG2_WIN];
    // Mean is never negative (top bit always 0), so a signed compare is exact.
    lo_hit   = $signed(mean_p0) < i_thresh_lo;
    hi_hit   = $signed(mean_p0) > i_thresh_hi;
    conv_nxt = lo_hit ? (conv_cnt + 1'b1) : '0;
    win_nxt  = win_cnt + 1'b1;
  end

  // ---- stage p1: registered state, window results and control outputs ----
  // Sequencer FSM with registered outputs; stop overrides everything else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_ready       <= 1'b0;
      o_adapt_en    <= 1'b0;
      o_coef_clr    <= 1'b0;
      o_converged   <= 1'b0;
      o_timeout     <= 1'b0;
      o_retrain_cnt <= '0;
      o_mean_err    <= '0;
      acc           <= '0;
      smp_cnt       <= '0;
      conv_cnt      <= '0;
      win_cnt       <= '0;
      clr_cnt       <= '0;
    end else if (i_stop) begin
      // Abort: controls drop, status (timeout, retrain count, mean) is kept.
      state       <= IDLE;
      o_ready     <= 1'b0;
      o_adapt_en  <= 1'b0;
      o_coef_clr  <= 1'b0;
      o_converged <= 1'b0;
      acc         <= '0;
      smp_cnt     <= '0;
      conv_cnt    <= '0;
      win_cnt     <= '0;
      clr_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= CLEAR;
            o_coef_clr    <= 1'b1;
            o_timeout     <= 1'b0;
            o_retrain_cnt <= '0;
            clr_cnt       <= '0;
            acc           <= '0;
            smp_cnt       <= '0;
            conv_cnt      <= '0;
          end
        end

        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state      <= TRAIN;
            o_coef_clr <= 1'b0;
            o_ready    <= 1'b1;
            o_adapt_en <= 1'b1;
            acc        <= '0;
            smp_cnt    <= '0;
            conv_cnt   <= '0;
            win_cnt    <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        TRAIN: begin
          if (vld_p0) begin
            if (done_p0) begin
              o_mean_err <= mean_p0;
              acc        <= '0;
              smp_cnt    <= '0;
              // Convergence takes precedence over a simultaneous timeout.
              if (conv_nxt == CONV_TGT) begin
                state       <= TRACK;
                o_adapt_en  <= 1'b0;
                o_converged <= 1'b1;
                conv_cnt    <= '0;
                win_cnt     <= '0;
              end else if (win_nxt == WIN_TGT) begin
                state      <= IDLE;
                o_timeout  <= 1'b1;
                o_ready    <= 1'b0;
                o_adapt_en <= 1'b0;
                conv_cnt   <= '0;
                win_cnt    <= '0;
              end else begin
                conv_cnt <= conv_nxt;
                win_cnt  <= win_nxt;
              end
            end else begin
              acc     <= sum_p0;
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end

        TRACK: begin
          if (vld_p0) begin
            if (done_p0) begin
              o_mean_err <= mean_p0;
              acc        <= '0;
              smp_cnt    <= '0;
              // Error has drifted up: go back to training without a clear.
              if (hi_hit) begin
                state       <= TRAIN;
                o_adapt_en  <= 1'b1;
                o_converged <= 1'b0;
                conv_cnt    <= '0;
                win_cnt     <= '0;
                if (o_retrain_cnt != 8'hFF)
                  o_retrain_cnt <= o_retrain_cnt + 8'd1;
              end
            end else begin
              acc     <= sum_p0;
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
